fir_seq_ctrl: RTL and testbench

//  Sequencer for one coefficient-ROM FIR band filter pair (left/right) in the equalizer.

---
 rtl/eq_pkg.sv | 6 +
 rtl/fir_seq_ctrl_tap_cntr.sv | 28 ++
 rtl/fir_seq_ctrl.sv | 65 ++++++
 tb/tb_fir_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared equalizer types and tap-count presets
package eq_pkg;
  typedef enum logic [1:0] {IDLE, SEQ, DRAIN, CAPT} seq_state_t;
  localparam int TAPS_LF = 1021;
  localparam int TAPS_HF = 1531;
endpackage

// File: rtl/fir_seq_ctrl_tap_cntr.sv
// tap_cntr: tap counter with a registered flag marking the final tap
module tap_cntr #(
  parameter int TAPS  = 1021,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  assign count_inc = count + 1'b1;
  // last is precomputed from the next count so it is true while count==TAPS-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      last  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      last  <= (TAPS == 1);
    end else if (en) begin
      count <= count_inc;
      last  <= (count_inc == CNT_W'(TAPS - 1));
    end
  end
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequences one FIR pass per primed sample and captures the L/R result
module fir_seq_ctrl
  import eq_pkg::*;
#(
  parameter int TAPS  = TAPS_LF,
  parameter int CNT_W = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        smpl_vld,
  input  logic        q_full,
  input  logic        clr_ovr,
  input  logic [15:0] lft_filt,
  input  logic [15:0] rght_filt,
  output logic        sequencing,
  output logic        busy,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        out_vld,
  output logic        overrun
);
  seq_state_t state, state_nxt;
  logic cnt_clr, last;
  tap_cntr #(.TAPS(TAPS), .CNT_W(CNT_W)) u_tap_cntr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (state == SEQ),
    .last  (last)
  );
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr   = smpl_vld && q_full;
        state_nxt = cnt_clr ? SEQ : IDLE;
      end
      SEQ:     state_nxt = last ? DRAIN : SEQ;
      DRAIN:   state_nxt = CAPT;
      default: state_nxt = IDLE;
    endcase
  end
  assign busy = (state != IDLE);
  // sequencing comes straight from a flop so the filter's edge detect sees no glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sequencing <= 1'b0;
      lft_out    <= '0;
      rght_out   <= '0;
      out_vld    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sequencing <= (state_nxt == SEQ);
      out_vld    <= (state == CAPT);
      overrun    <= (smpl_vld && busy) || (overrun && !clr_ovr);
      if (state == CAPT) begin
        lft_out  <= lft_filt;
        rght_out <= rght_filt;
      end
    end
  end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: directed and randomized checks of fir_seq_ctrl against a pass-timeline model
module tb_fir_seq_ctrl;
  localparam int TAPS  = 8;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst_n, smpl_vld, q_full, clr_ovr;
  logic [15:0] lft_filt, rght_filt;
  logic sequencing, busy, out_vld, overrun;
  logic [15:0] lft_out, rght_out;
  int checks = 0;
  int errs   = 0;
  // model: k is the cycle index inside the current pass (first SEQ cycle = 0), -1 when idle
  int k = -1;
  logic e_ovr = 1'b0;
  logic e_vld = 1'b0;
  logic [15:0] e_l = '0;
  logic [15:0] e_r = '0;
  logic last_seq = 1'b0;
  logic seen_hi  = 1'b0;
  int low_run = 0;
  int hi, at;
  logic found;

  fir_seq_ctrl #(.TAPS(TAPS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smpl_vld   (smpl_vld),
    .q_full     (q_full),
    .clr_ovr    (clr_ovr),
    .lft_filt   (lft_filt),
    .rght_filt  (rght_filt),
    .sequencing (sequencing),
    .busy       (busy),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .out_vld    (out_vld),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k = -1; e_ovr = 1'b0; e_vld = 1'b0; e_l = '0; e_r = '0;
    last_seq = 1'b0; seen_hi = 1'b0; low_run = 0;
  endtask

  task automatic step();
    logic pass_busy;
    @(posedge clk);
    pass_busy = (k >= 0);
    e_ovr = (smpl_vld && pass_busy) || (e_ovr && !clr_ovr);
    e_vld = (k == TAPS + 1);
    if (k == TAPS + 1) begin
      e_l = lft_filt;
      e_r = rght_filt;
    end
    if (pass_busy) k = (k == TAPS + 1) ? -1 : k + 1;
    else k = (smpl_vld && q_full) ? 0 : -1;
    #1;
    chk("sequencing", {15'b0, sequencing}, {15'b0, (k >= 0 && k < TAPS)});
    chk("busy", {15'b0, busy}, {15'b0, (k >= 0)});
    chk("out_vld", {15'b0, out_vld}, {15'b0, e_vld});
    chk("overrun", {15'b0, overrun}, {15'b0, e_ovr});
    chk("lft_out", lft_out, e_l);
    chk("rght_out", rght_out, e_r);
    if (sequencing && !last_seq && seen_hi) chk("seq_gap>=2", {15'b0, (low_run >= 2)}, 16'd1);
    if (sequencing) seen_hi = 1'b1;
    low_run  = sequencing ? 0 : low_run + 1;
    last_seq = sequencing;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seq"}, {15'b0, sequencing}, 16'd0);
    chk({tag, "_busy"}, {15'b0, busy}, 16'd0);
    chk({tag, "_vld"}, {15'b0, out_vld}, 16'd0);
    chk({tag, "_ovr"}, {15'b0, overrun}, 16'd0);
    chk({tag, "_lft"}, lft_out, 16'd0);
    chk({tag, "_rght"}, rght_out, 16'd0);
  endtask

  task automatic run_to_vld(input string tag);
    found = 1'b0;
    for (int i = 0; i < 3 * TAPS && !found; i++) begin
      step();
      found = out_vld;
    end
    chk({tag, "_vld_seen"}, {15'b0, found}, 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; smpl_vld = 1'b0; q_full = 1'b1; clr_ovr = 1'b0;
    lft_filt = 16'h1234; rght_filt = 16'h8001;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step();
    // single pass timing plus fixed filter values at capture
    smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    hi = 0; at = -1;
    for (int i = 0; i < 12; i++) begin
      if (sequencing) hi++;
      if (out_vld) at = i;
      step();
    end
    chk("seq_high_cycles", 16'(hi), 16'(TAPS));
    chk("out_vld_cycle", 16'(at), 16'(TAPS + 2));
    chk("capt_lft", lft_out, 16'h1234);
    chk("capt_rght", rght_out, 16'h8001);
    lft_filt = 16'hdead; rght_filt = 16'h0bad;
    for (int i = 0; i < 3; i++) step();
    chk("hold_lft", lft_out, 16'h1234);
    chk("hold_rght", rght_out, 16'h8001);
    // sample into an unprimed queue is ignored
    q_full = 1'b0; smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("unprimed_busy", {15'b0, busy}, 16'd0);
    // drop at SEQ cycle 3 with q_full falling mid-pass
    q_full = 1'b1; smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    for (int i = 0; i < 3; i++) step();
    smpl_vld = 1'b1; q_full = 1'b0;
    step();
    smpl_vld = 1'b0;
    run_to_vld("drop");
    chk("drop_overrun", {15'b0, overrun}, 16'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("clr_overrun", {15'b0, overrun}, 16'd0);
    q_full = 1'b1; smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    step();
    smpl_vld = 1'b1; clr_ovr = 1'b1;
    step();
    smpl_vld = 1'b0; clr_ovr = 1'b0;
    chk("clr_vs_drop", {15'b0, overrun}, 16'd1);
    run_to_vld("clrdrop");
    // back-to-back: sample in the out_vld cycle starts the next pass
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0; smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    run_to_vld("b2b");
    smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    chk("b2b_restart", {15'b0, sequencing}, 16'd1);
    chk("b2b_no_ovr", {15'b0, overrun}, 16'd0);
    run_to_vld("b2b2");
    // async reset at SEQ cycle 5
    smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    smpl_vld = 1'b1;
    step();
    smpl_vld = 1'b0;
    hi = 0;
    for (int i = 0; i < TAPS + 4; i++) begin
      if (sequencing) hi++;
      step();
    end
    chk("post_reset_pass", 16'(hi), 16'(TAPS));
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      q_full    = ($urandom_range(0, 3) != 0);
      smpl_vld  = ($urandom_range(0, 5) == 0);
      clr_ovr   = ($urandom_range(0, 15) == 0);
      lft_filt  = 16'($urandom);
      rght_filt = 16'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
